// File: rtl/cc_matrix_max7219_tx_pkg.sv
// cc_matrix_max7219_tx shared definitions:
// MAX7219 register map, init table, FSM encoding.
package cc_matrix_max7219_tx_pkg;

  localparam logic [7:0] ADDR_DIGIT0    = 8'h01;
  localparam logic [7:0] ADDR_DECODE    = 8'h09;
  localparam logic [7:0] ADDR_INTENSITY = 8'h0A;
  localparam logic [7:0] ADDR_SCANLIMIT = 8'h0B;
  localparam logic [7:0] ADDR_SHUTDOWN  = 8'h0C;
  localparam logic [7:0] ADDR_TEST      = 8'h0F;

  localparam int INIT_WORDS  = 5;
  localparam int FRAME_WORDS = 8;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_LOAD_WORD,
    ST_SHIFT,
    ST_LATCH
  } state_t;

  function automatic int word_cycles(int clkdiv);
    return 33 * clkdiv;
  endfunction

  function automatic logic [15:0] init_word(
    logic [2:0] idx,
    logic [3:0] intensity
  );
    logic [15:0] w;
    case (idx)
      3'd0:    w = {ADDR_TEST, 8'h00};
      3'd1:    w = {ADDR_DECODE, 8'h00};
      3'd2:    w = {ADDR_INTENSITY, 4'h0, intensity};
      3'd3:    w = {ADDR_SCANLIMIT, 8'h07};
      3'd4:    w = {ADDR_SHUTDOWN, 8'h01};
      default: w = 16'h0000;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/cc_matrix_max7219_tx_if.sv
// cc_matrix_max7219_tx frame handshake:
// eight row buses plus valid/ready and done.
interface cc_matrix_max7219_tx_if #(
  parameter int DW = 8
);
  logic [DW-1:0] CC_MATRIX_TX_ROW_0_In_Bus;
  logic [DW-1:0] CC_MATRIX_TX_ROW_1_In_Bus;
  logic [DW-1:0] CC_MATRIX_TX_ROW_2_In_Bus;
  logic [DW-1:0] CC_MATRIX_TX_ROW_3_In_Bus;
  logic [DW-1:0] CC_MATRIX_TX_ROW_4_In_Bus;
  logic [DW-1:0] CC_MATRIX_TX_ROW_5_In_Bus;
  logic [DW-1:0] CC_MATRIX_TX_ROW_6_In_Bus;
  logic [DW-1:0] CC_MATRIX_TX_ROW_7_In_Bus;
  logic          CC_MATRIX_TX_VALID_InHigh;
  logic          CC_MATRIX_TX_READY_OutHigh;
  logic          CC_MATRIX_TX_DONE_OutHigh;

  modport master (
    output CC_MATRIX_TX_ROW_0_In_Bus, CC_MATRIX_TX_ROW_1_In_Bus,
    output CC_MATRIX_TX_ROW_2_In_Bus, CC_MATRIX_TX_ROW_3_In_Bus,
    output CC_MATRIX_TX_ROW_4_In_Bus, CC_MATRIX_TX_ROW_5_In_Bus,
    output CC_MATRIX_TX_ROW_6_In_Bus, CC_MATRIX_TX_ROW_7_In_Bus,
    output CC_MATRIX_TX_VALID_InHigh,
    input  CC_MATRIX_TX_READY_OutHigh, CC_MATRIX_TX_DONE_OutHigh
  );

  modport slave (
    input  CC_MATRIX_TX_ROW_0_In_Bus, CC_MATRIX_TX_ROW_1_In_Bus,
    input  CC_MATRIX_TX_ROW_2_In_Bus, CC_MATRIX_TX_ROW_3_In_Bus,
    input  CC_MATRIX_TX_ROW_4_In_Bus, CC_MATRIX_TX_ROW_5_In_Bus,
    input  CC_MATRIX_TX_ROW_6_In_Bus, CC_MATRIX_TX_ROW_7_In_Bus,
    input  CC_MATRIX_TX_VALID_InHigh,
    output CC_MATRIX_TX_READY_OutHigh, CC_MATRIX_TX_DONE_OutHigh
  );
endinterface

// File: rtl/cc_matrix_max7219_tx_shifter.sv
// 16-bit MAX7219 word serialiser: LOAD low for 16 bits,
// then LOAD high for one divider period as the word gap.
module cc_spi_word_shifter #(
  parameter int CLKDIV = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] word,
  input  logic        start,
  output logic        din,
  output logic        sclk,
  output logic        load,
  output logic        last,
  output logic        done
);

  localparam logic [7:0] DIV_MAX = 8'(CLKDIV - 1);

  logic        busy;
  logic        gap;
  logic [7:0]  div;
  logic [3:0]  bitcnt;
  logic [15:0] sr;

  assign din  = sr[15];
  assign last = busy & ~gap & sclk & (div == DIV_MAX)
              & (bitcnt == 4'd0);
  assign done = busy & gap & (div == DIV_MAX);

  // divider, bit counter and shift register; start wins over all
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy   <= 1'b0;
      gap    <= 1'b0;
      div    <= 8'd0;
      bitcnt <= 4'd15;
      sr     <= 16'h0000;
      sclk   <= 1'b0;
      load   <= 1'b1;
    end else if (start) begin
      busy   <= 1'b1;
      gap    <= 1'b0;
      div    <= 8'd0;
      bitcnt <= 4'd15;
      sr     <= word;
      sclk   <= 1'b0;
      load   <= 1'b0;
    end else if (busy) begin
      if (div == DIV_MAX) begin
        div <= 8'd0;
        if (gap) begin
          busy <= 1'b0;
          gap  <= 1'b0;
        end else if (!sclk) begin
          sclk <= 1'b1;
        end else begin
          sclk <= 1'b0;
          sr   <= {sr[14:0], 1'b0};
          if (bitcnt == 4'd0) begin
            load <= 1'b1;
            gap  <= 1'b1;
          end else begin
            bitcnt <= bitcnt - 4'd1;
          end
        end
      end else begin
        div <= div + 8'd1;
      end
    end
  end

endmodule

// File: rtl/cc_matrix_max7219_tx.sv
// MAX7219 transmit end: sends the init words after reset,
// then serialises each accepted 8-row frame as digit words.
module cc_matrix_max7219_tx
  import cc_matrix_max7219_tx_pkg::*;
#(
  parameter int         DATAWIDTH_BUS = 8,
  parameter int         CLKDIV        = 4,
  parameter logic [3:0] INTENSITY     = 4'h8
) (
  input  logic                  CC_MATRIX_TX_CLOCK_50,
  input  logic                  CC_MATRIX_TX_RESET_InLow,
  cc_matrix_max7219_tx_if.slave bus,
  output logic                  CC_MATRIX_TX_DIN_Out,
  output logic                  CC_MATRIX_TX_CLK_Out,
  output logic                  CC_MATRIX_TX_LOAD_Out
);

  logic clk;
  logic rst_n;
  assign clk   = CC_MATRIX_TX_CLOCK_50;
  assign rst_n = CC_MATRIX_TX_RESET_InLow;

  state_t state, nxt_state;
  logic [2:0] idx, nxt_idx;
  logic       init_q, nxt_init;
  logic       done_q, nxt_done;
  logic       start, cap, last_word;
  logic       sh_last, sh_done;
  logic [15:0] word;
  logic [DATAWIDTH_BUS-1:0] row_sel;
  logic [7:0][DATAWIDTH_BUS-1:0] rows_in, fbuf;

  assign rows_in[0] = bus.CC_MATRIX_TX_ROW_0_In_Bus;
  assign rows_in[1] = bus.CC_MATRIX_TX_ROW_1_In_Bus;
  assign rows_in[2] = bus.CC_MATRIX_TX_ROW_2_In_Bus;
  assign rows_in[3] = bus.CC_MATRIX_TX_ROW_3_In_Bus;
  assign rows_in[4] = bus.CC_MATRIX_TX_ROW_4_In_Bus;
  assign rows_in[5] = bus.CC_MATRIX_TX_ROW_5_In_Bus;
  assign rows_in[6] = bus.CC_MATRIX_TX_ROW_6_In_Bus;
  assign rows_in[7] = bus.CC_MATRIX_TX_ROW_7_In_Bus;

  assign bus.CC_MATRIX_TX_READY_OutHigh = (state == ST_IDLE);
  assign bus.CC_MATRIX_TX_DONE_OutHigh  = done_q;

  // FSM state, word index, init/frame mode and done pulse
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= ST_INIT;
      idx    <= 3'd0;
      init_q <= 1'b1;
      done_q <= 1'b0;
    end else begin
      state  <= nxt_state;
      idx    <= nxt_idx;
      init_q <= nxt_init;
      done_q <= nxt_done;
    end
  end

  // frame buffer: rows are frozen on the accept edge
  always_ff @(posedge clk) begin
    if (cap) fbuf <= rows_in;
  end

  // next state; start fires on the cycle before LOAD falls
  always_comb begin
    nxt_state = state;
    nxt_idx   = idx;
    nxt_init  = init_q;
    nxt_done  = 1'b0;
    start     = 1'b0;
    cap       = 1'b0;
    last_word = init_q ? (idx == 3'(INIT_WORDS - 1))
                       : (idx == 3'(FRAME_WORDS - 1));
    unique case (state)
      ST_INIT: begin
        start     = 1'b1;
        nxt_idx   = 3'd0;
        nxt_init  = 1'b1;
        nxt_state = ST_LOAD_WORD;
      end
      ST_IDLE: begin
        if (bus.CC_MATRIX_TX_VALID_InHigh) begin
          start     = 1'b1;
          cap       = 1'b1;
          nxt_idx   = 3'd0;
          nxt_init  = 1'b0;
          nxt_state = ST_LOAD_WORD;
        end
      end
      ST_LOAD_WORD: nxt_state = ST_SHIFT;
      ST_SHIFT: begin
        if (sh_last) nxt_state = ST_LATCH;
      end
      ST_LATCH: begin
        if (sh_done) begin
          if (last_word) begin
            nxt_state = ST_IDLE;
            nxt_done  = ~init_q;
          end else begin
            start     = 1'b1;
            nxt_idx   = idx + 3'd1;
            nxt_state = ST_LOAD_WORD;
          end
        end
      end
      default: nxt_state = ST_INIT;
    endcase
    row_sel = cap ? rows_in[nxt_idx] : fbuf[nxt_idx];
    word    = nxt_init ? init_word(nxt_idx, INTENSITY)
                       : {ADDR_DIGIT0 + 8'(nxt_idx), row_sel};
  end

  cc_spi_word_shifter #(
    .CLKDIV(CLKDIV)
  ) u_shifter (
    .clk   (clk),
    .rst_n (rst_n),
    .word  (word),
    .start (start),
    .din   (CC_MATRIX_TX_DIN_Out),
    .sclk  (CC_MATRIX_TX_CLK_Out),
    .load  (CC_MATRIX_TX_LOAD_Out),
    .last  (sh_last),
    .done  (sh_done)
  );

endmodule

// File: tb/tb_cc_matrix_max7219_tx.sv
// Directed bench for cc_matrix_max7219_tx at CLKDIV=4 and CLKDIV=1,
// decoding the serial link back into 16-bit words.
module tb_cc_matrix_max7219_tx;

  typedef logic [7:0][7:0] rows_t;

  logic clk = 1'b0;
  logic rst_n;
  always #10 clk = ~clk;

  cc_matrix_max7219_tx_if bus4 ();
  cc_matrix_max7219_tx_if bus1 ();
  logic din4, sclk4, load4;
  logic din1, sclk1, load1;

  cc_matrix_max7219_tx #(.CLKDIV(4)) dut4 (
    .CC_MATRIX_TX_CLOCK_50   (clk),
    .CC_MATRIX_TX_RESET_InLow(rst_n),
    .bus                     (bus4),
    .CC_MATRIX_TX_DIN_Out    (din4),
    .CC_MATRIX_TX_CLK_Out    (sclk4),
    .CC_MATRIX_TX_LOAD_Out   (load4)
  );

  cc_matrix_max7219_tx #(.CLKDIV(1)) dut1 (
    .CC_MATRIX_TX_CLOCK_50   (clk),
    .CC_MATRIX_TX_RESET_InLow(rst_n),
    .bus                     (bus1),
    .CC_MATRIX_TX_DIN_Out    (din1),
    .CC_MATRIX_TX_CLK_Out    (sclk1),
    .CC_MATRIX_TX_LOAD_Out   (load1)
  );

  int nvec = 0;
  int nmis = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  // serial decoders
  logic [15:0] sh4, sh1;
  int nb4 = 0, nb1 = 0, ndone4 = 0;
  logic ps4 = 1'b0, pl4 = 1'b1, ps1 = 1'b0, pl1 = 1'b1, pd1 = 1'b0;
  logic [15:0] q4[$];
  logic [15:0] q1[$];
  int falls1[$];
  int lastrise1 = 0, badclk1 = 0, baddin1 = 0;
  bit inword1 = 1'b0;

  always @(negedge clk) begin
    if (sclk4 && !ps4) begin sh4 = {sh4[14:0], din4}; nb4++; end
    if (load4 && !pl4) begin
      if (nb4 == 16) q4.push_back(sh4);
      nb4 = 0;
    end
    if (!load4 && pl4) nb4 = 0;
    if (bus4.CC_MATRIX_TX_DONE_OutHigh) ndone4++;
    ps4 = sclk4; pl4 = load4;
  end

  always @(negedge clk) begin
    if (sclk1 && !ps1) begin
      sh1 = {sh1[14:0], din1}; nb1++;
      if (inword1 && (cyc - lastrise1) != 2) badclk1++;
      if (din1 !== pd1) baddin1++;
      lastrise1 = cyc; inword1 = 1'b1;
    end
    if (load1 && !pl1) begin
      if (nb1 == 16) q1.push_back(sh1);
      nb1 = 0;
    end
    if (!load1 && pl1) begin nb1 = 0; inword1 = 1'b0; falls1.push_back(cyc); end
    ps1 = sclk1; pl1 = load1; pd1 = din1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive4(input rows_t r);
    bus4.CC_MATRIX_TX_ROW_0_In_Bus = r[0];
    bus4.CC_MATRIX_TX_ROW_1_In_Bus = r[1];
    bus4.CC_MATRIX_TX_ROW_2_In_Bus = r[2];
    bus4.CC_MATRIX_TX_ROW_3_In_Bus = r[3];
    bus4.CC_MATRIX_TX_ROW_4_In_Bus = r[4];
    bus4.CC_MATRIX_TX_ROW_5_In_Bus = r[5];
    bus4.CC_MATRIX_TX_ROW_6_In_Bus = r[6];
    bus4.CC_MATRIX_TX_ROW_7_In_Bus = r[7];
  endtask

  task automatic drive1(input rows_t r);
    bus1.CC_MATRIX_TX_ROW_0_In_Bus = r[0];
    bus1.CC_MATRIX_TX_ROW_1_In_Bus = r[1];
    bus1.CC_MATRIX_TX_ROW_2_In_Bus = r[2];
    bus1.CC_MATRIX_TX_ROW_3_In_Bus = r[3];
    bus1.CC_MATRIX_TX_ROW_4_In_Bus = r[4];
    bus1.CC_MATRIX_TX_ROW_5_In_Bus = r[5];
    bus1.CC_MATRIX_TX_ROW_6_In_Bus = r[6];
    bus1.CC_MATRIX_TX_ROW_7_In_Bus = r[7];
  endtask

  task automatic wait_done4(input int limit);
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (bus4.CC_MATRIX_TX_DONE_OutHigh) break;
    end
  endtask

  task automatic chk_frame4(input string tag, input int base, input rows_t r);
    for (int k = 0; k < 8; k++)
      chk($sformatf("%s_w%0d", tag, k), 32'(q4[base + k]), {16'h0, 8'(k + 1), r[k]});
  endtask

  logic [15:0] initw [5];
  rows_t ra, rb, rc, rd, rx;
  int rel, a, nd0, rr4, rr1;

  initial begin
    initw = '{16'h0F00, 16'h0900, 16'h0A08, 16'h0B07, 16'h0C01};
    ra = {8'h81, 8'h42, 8'h24, 8'h18, 8'h18, 8'h24, 8'h42, 8'h81};
    rb = {8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
    rc = {8'h43, 8'h42, 8'h41, 8'h40, 8'h3F, 8'h3E, 8'h3D, 8'h3C};
    rd = {8{8'hA5}};
    rx = {8{8'hFF}};
    rst_n = 1'b0;
    drive4('0); drive1('0);
    bus4.CC_MATRIX_TX_VALID_InHigh = 1'b0;
    bus1.CC_MATRIX_TX_VALID_InHigh = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(bus4.CC_MATRIX_TX_READY_OutHigh), 0);
    chk("rst_done", 32'(bus4.CC_MATRIX_TX_DONE_OutHigh), 0);
    chk("rst_din", 32'(din4), 0);
    chk("rst_clk", 32'(sclk4), 0);
    chk("rst_load", 32'(load4), 1);

    // 1: init sequence and first READY
    q4.delete();
    rst_n = 1'b1; rel = cyc;
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      if (bus4.CC_MATRIX_TX_READY_OutHigh) break;
    end
    chk("ready_rise", 32'(cyc - rel), 661);
    chk("init_count", 32'(q4.size()), 5);
    for (int k = 0; k < 5; k++)
      chk($sformatf("init_w%0d", k), 32'(q4[k]), 32'(initw[k]));

    // 2+3: one frame, rows change after accept, VALID ignored while busy
    q4.delete(); nd0 = ndone4;
    drive4(ra); bus4.CC_MATRIX_TX_VALID_InHigh = 1'b1; a = cyc;
    chk("pre_load", 32'(load4), 1);
    @(negedge clk);
    chk("acc_ready_fall", 32'(bus4.CC_MATRIX_TX_READY_OutHigh), 0);
    chk("acc_load_fall", 32'(load4), 0);
    drive4(rx); bus4.CC_MATRIX_TX_VALID_InHigh = 1'b0;
    repeat (100) @(negedge clk);
    drive4(rb); bus4.CC_MATRIX_TX_VALID_InHigh = 1'b1;
    repeat (5) @(negedge clk);
    bus4.CC_MATRIX_TX_VALID_InHigh = 1'b0;
    wait_done4(1200);
    chk("f1_done_cyc", 32'(cyc - a), 1057);
    chk("f1_done_ready", 32'(bus4.CC_MATRIX_TX_READY_OutHigh), 1);
    @(negedge clk);
    chk("f1_done_pulse", 32'(bus4.CC_MATRIX_TX_DONE_OutHigh), 0);
    chk("f1_ndone", 32'(ndone4 - nd0), 1);
    chk("f1_count", 32'(q4.size()), 8);
    chk_frame4("f1", 0, ra);

    // 4: back-to-back frames with VALID held high
    q4.delete();
    drive4(rb); bus4.CC_MATRIX_TX_VALID_InHigh = 1'b1; a = cyc;
    wait_done4(1200);
    chk("b1_done_cyc", 32'(cyc - a), 1057);
    drive4(rc);
    @(negedge clk);
    chk("b2_load_fall", 32'(load4), 0);
    chk("b2_ready_fall", 32'(bus4.CC_MATRIX_TX_READY_OutHigh), 0);
    bus4.CC_MATRIX_TX_VALID_InHigh = 1'b0;
    wait_done4(1200);
    chk("b2_done_cyc", 32'(cyc - a), 2114);
    chk("b_count", 32'(q4.size()), 16);
    chk_frame4("b1", 0, rb);
    chk_frame4("b2", 8, rc);

    // 5: reset during bit 7 of word 3 (CLK high phase)
    @(negedge clk);
    drive4(rd); bus4.CC_MATRIX_TX_VALID_InHigh = 1'b1; a = cyc;
    @(negedge clk);
    bus4.CC_MATRIX_TX_VALID_InHigh = 1'b0;
    for (int i = 0; i < 600 && cyc < a + 466; i++) @(negedge clk);
    chk("mid_load", 32'(load4), 0);
    chk("mid_clk", 32'(sclk4), 1);
    chk("mid_din", 32'(din4), 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_load", 32'(load4), 1);
    chk("abort_clk", 32'(sclk4), 0);
    chk("abort_din", 32'(din4), 0);
    @(negedge clk);
    q4.delete(); q1.delete(); falls1.delete();
    badclk1 = 0; baddin1 = 0;
    rst_n = 1'b1; rel = cyc; rr4 = -1; rr1 = -1;
    for (int i = 0; i < 800 && (rr4 < 0 || rr1 < 0); i++) begin
      @(negedge clk);
      if (rr4 < 0 && bus4.CC_MATRIX_TX_READY_OutHigh) rr4 = cyc - rel;
      if (rr1 < 0 && bus1.CC_MATRIX_TX_READY_OutHigh) rr1 = cyc - rel;
    end
    chk("re_ready_rise", 32'(rr4), 661);
    chk("re_count", 32'(q4.size()), 5);
    for (int k = 0; k < 5; k++)
      chk($sformatf("re_w%0d", k), 32'(q4[k]), 32'(initw[k]));

    // 6: CLKDIV=1 instance
    chk("d1_ready_rise", 32'(rr1), 166);
    drive1(ra); bus1.CC_MATRIX_TX_VALID_InHigh = 1'b1;
    a = cyc;
    @(negedge clk);
    bus1.CC_MATRIX_TX_VALID_InHigh = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (bus1.CC_MATRIX_TX_DONE_OutHigh) break;
      @(negedge clk);
    end
    chk("d1_done_cyc", 32'(cyc - a), 265);
    chk("d1_count", 32'(q1.size()), 13);
    for (int k = 0; k < 5; k++)
      chk($sformatf("d1_init_w%0d", k), 32'(q1[k]), 32'(initw[k]));
    for (int k = 0; k < 8; k++)
      chk($sformatf("d1_w%0d", k), 32'(q1[5 + k]), {16'h0, 8'(k + 1), ra[k]});
    chk("d1_falls", 32'(falls1.size()), 13);
    chk("d1_init_word_len", 32'(falls1[1] - falls1[0]), 33);
    chk("d1_frame_word_len", 32'(falls1[6] - falls1[5]), 33);
    chk("d1_first_fall", 32'(falls1[5] - a), 1);
    chk("d1_clk_period", 32'(badclk1), 0);
    chk("d1_din_stable", 32'(baddin1), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
